// File: rtl/run_det_pkg.sv
// Shared definitions for the multi-lane run detector: overlap-mode encodings
// and a saturating increment helper for the hit counters.
package run_det_pkg;

  localparam logic MODE_STICKY = 1'b0;
  localparam logic MODE_NONOVL = 1'b1;

  // Increment that stops at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/run_detector_lane.sv
// One detector lane: counts consecutive qualified TARGET bits, flags a full run,
// pulses hit on entry to a full run and keeps a saturating hit tally.
module run_detector_lane
  import run_det_pkg::*;
#(
  parameter int unsigned RUN_LEN = 2,
  parameter logic        TARGET  = 1'b0,
  parameter int unsigned HIT_W   = 8,
  localparam int unsigned CNT_W  = $clog2(RUN_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             mode,
  input  logic             x_valid,
  input  logic             x,
  output logic             y,
  output logic             hit,
  output logic [CNT_W-1:0] run_count,
  output logic [HIT_W-1:0] hit_count
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [31:0]      HIT_MAX = 32'({HIT_W{1'b1}});
  localparam logic             SINGLE  = (RUN_LEN == 32'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HIT_W-1:0] hc_q, hc_d;
  logic             hit_q, hit_d;
  logic             y_q, y_d;

  // Next run count and hit decision for the current bit.
  always_comb begin
    cnt_d = cnt_q;
    hit_d = 1'b0;
    if (x_valid) begin
      if (x != TARGET) begin
        cnt_d = '0;
      end else if (cnt_q != RUN_MAX) begin
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        hit_d = (CNT_W'(cnt_q + CNT_W'(1)) == RUN_MAX);
      end else if (mode == MODE_NONOVL) begin
        // A single-bit run restarts straight back into a full run, so it re-hits.
        cnt_d = CNT_W'(1);
        hit_d = SINGLE;
      end
    end
    hc_d = hit_d ? HIT_W'(sat_inc(32'(hc_q), HIT_MAX)) : hc_q;
    y_d  = (cnt_d == RUN_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
      hc_q  <= '0;
      hit_q <= 1'b0;
      y_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hc_q  <= hc_d;
      hit_q <= hit_d;
      y_q   <= y_d;
    end
  end

  assign y         = y_q;
  assign hit       = hit_q;
  assign run_count = cnt_q;
  assign hit_count = hc_q;

endmodule

// File: rtl/run_length_detector.sv
// Multi-lane serial run detector: CHANNELS independent lanes, packed status buses
// and a summary flag for the interrupt logic.
module run_length_detector
  import run_det_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned RUN_LEN  = 2,
  parameter logic        TARGET   = 1'b0,
  parameter int unsigned HIT_W    = 8,
  localparam int unsigned CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       x_valid,
  input  logic [CHANNELS-1:0]       x,
  output logic [CHANNELS-1:0]       y,
  output logic [CHANNELS-1:0]       hit,
  output logic                      any_y,
  output logic [CHANNELS*CNT_W-1:0] run_count,
  output logic [CHANNELS*HIT_W-1:0] hit_count
);

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_lane
    run_detector_lane #(
      .RUN_LEN (RUN_LEN),
      .TARGET  (TARGET),
      .HIT_W   (HIT_W)
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .mode      (mode),
      .x_valid   (x_valid[i]),
      .x         (x[i]),
      .y         (y[i]),
      .hit       (hit[i]),
      .run_count (run_count[i*CNT_W +: CNT_W]),
      .hit_count (hit_count[i*HIT_W +: HIT_W])
    );
  end

  // Derived only from registered lane flags, so no combinational path from x.
  assign any_y = |y;

endmodule
